// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: each trigger on din[i] yields a dout[i] pulse of len cycles (0 acts as 1), then a done strobe.
// Latency 1 cycle din->dout; no backpressure, so triggers landing in a non-retriggerable pulse are dropped.
module pulse_stretch #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [CH-1:0] din,
    input  logic [CW-1:0] len,
    input  logic          mode_edge,
    input  logic          mode_retrig,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] done,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CH-1:0] prev_q;
    logic [CH-1:0] prev_d;
    logic [CH-1:0] done_q;
    logic [CH-1:0] done_d;
    logic [CH-1:0] trig;
    logic [CW-1:0] reload;

    // Reload value is L-1 where a zero length behaves as one cycle.
    assign reload = (len == '0) ? '0 : (len - CW'(1));

    always_comb begin
        prev_d = din;
        done_d = '0;
        trig   = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            trig[i]    = mode_edge ? (din[i] & ~prev_q[i]) : din[i];
            if (state_q[i] == IDLE) begin
                if (trig[i]) begin
                    state_d[i] = HOLD;
                    cnt_d[i]   = reload;
                end
            end else begin
                if (mode_retrig && trig[i]) begin
                    cnt_d[i] = reload;
                end else if (cnt_q[i] == '0) begin
                    state_d[i] = IDLE;
                    done_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q <= '0;
            done_q <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q <= prev_d;
            done_q <= done_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < CH; i++) begin
            dout[i] = (state_q[i] == HOLD);
        end
    end

    assign done = done_q;
    assign busy = |dout;

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Multi-channel, runtime-programmable pulse stretcher. It is the parametrised successor to the fixed-length single-channel delay/LED stretcher used in the UART calculator ALU path. Each channel turns a short trigger on `din` into an output pulse exactly `len` cycles long. Edge/level trigger and retrigger behaviour are selectable at runtime, and each channel reports completion. It sits between the ALU/UART status strobes and the board LEDs or slow downstream logic.

## Interface
- `CH`, default 4: number of independent channels, ≥1.
- `CW`, default 8: width of the length/counter field, ≥1. Maximum pulse is 2^CW−1 cycles.

- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `din`  in  CH: per-channel trigger inputs, synchronous to `clk`.
- `len`  in  CW: stretch length in cycles, shared by all channels. Sampled at each (re)trigger.
- `mode_edge`  in  1: 1 = trigger on rising edge of `din[i]`; 0 = trigger on level high.
- `mode_retrig`  in  1: 1 = a trigger during an active pulse restarts the count; 0 = triggers during a pulse are ignored.
- `dout`  out  CH: stretched pulses, registered.
- `done`  out  CH: one-cycle strobe per channel when its pulse ends, registered.
- `busy`  out  1: OR-reduction of `dout`.

## Operation
- Per-channel state: `state[i]` ∈ {IDLE, HOLD}, counter `cnt[i]` of CW bits, and `din_d[i]` (previous `din`, updated every cycle in every state).
- Trigger: `trig[i]` = `mode_edge` ? (`din[i]` & ~`din_d[i]`) : `din[i]`.
- Effective length: `L` = (`len` == 0) ? 1 : `len`. A value of 0 is treated as 1 and never produces a zero-length or 2^CW pulse.
- IDLE:
  - If `trig[i]`: go to HOLD and load `cnt[i]` = L−1.
  - Otherwise stay in IDLE.
- HOLD:
  - If `mode_retrig` & `trig[i]`: reload `cnt[i]` = L−1 and stay in HOLD. Retrigger has priority over expiry.
  - Else if `cnt[i]` == 0: go to IDLE and assert `done[i]` for the next cycle.
  - Else: `cnt[i]` decrements by 1. No wrap is possible, since the 0 case exits.
- `dout[i]` = (`state[i]` == HOLD). It is driven directly from the state register and carries no combinational path from `din`.
- Channels are fully independent. `len` and the mode inputs are shared and evaluated every cycle, so a mode change takes effect on the next clock edge.
- Reset, at any time including mid-pulse: all `state` → IDLE, `cnt` → 0, `din_d` → 0, `dout` → 0, `done` → 0, `busy` → 0. These take effect immediately and asynchronously.

## Timing
- Trigger sampled at edge k: `dout[i]` goes high after edge k and stays high through edge k+L−1. It is low after edge k+L, so the high time is exactly L cycles.
- `done[i]` is high for exactly the one cycle after edge k+L, the first cycle in which `dout[i]` is low.
- Level mode with `din` held high and no retrigger: the pattern repeats as L cycles high, 1 cycle low.
- Level mode with retrigger and `din` held high: `dout` stays high continuously. It falls L cycles after the last edge at which `din` was sampled high.
- Edge mode:
  - `din` held high produces one pulse only.
  - A rising edge that arrives while a non-retrig pulse is active is lost and is not queued.
  - A rising edge at the expiry edge with retrigger off is also lost, because the state is still HOLD.
- Edge detection after reset: `din_d` = 0. If `din` is already high at the first edge after reset release, that counts as a rising edge.
- `len` changes during HOLD do not alter the running count. Only a reload samples `len`.
- Latency from `din` to `dout` is 1 cycle. `busy` follows `dout` in the same cycle.

## Test plan
- Reset, `len`=5, `mode_edge`=1, 1-cycle pulse on `din[0]` → `dout[0]` high for exactly 5 cycles starting 1 cycle after the trigger. `done[0]` is a single-cycle pulse on cycle 6. All other channels stay 0.
- `len`=0 and `len`=255 (CW=8), single edge trigger → `dout` high for 1 cycle and for 255 cycles respectively. No wrap occurs and no extra `done` is produced.
- Level mode, `mode_retrig`=0, `len`=3, `din[1]` held high for 10 cycles → `dout[1]` shows 3 high, 1 low, 3 high, 1 low, then 3 high. The third pulse starts on the last cycle `din` is sampled high and ends 2 cycles after `din` falls. `done[1]` pulses once after each pulse, 3 times in total.
- `mode_retrig`=1, edge mode, `len`=4, edges on `din[2]` 3 cycles apart, three times → `dout[2]` is high continuously for 3+3+4=10 cycles. A single `done` follows. With `mode_retrig`=0 and the same stimulus: pulse 1 runs 4 cycles and the 2nd edge is ignored. The 3rd edge starts a new 4-cycle pulse 2 cycles after pulse 1 ends, giving two `done` strobes.
- All 4 channels triggered on different cycles with `len` changed from 2 to 6 mid-run → each pulse length matches `len` as sampled at its own trigger. `busy` equals the OR of `dout` every cycle.
- Deassert `n_rst` during HOLD with `cnt`=3 → `dout`, `done` and `busy` go to 0 immediately. After reset is released, no pulse resumes until a new trigger arrives.
